l2_assoc_cache: RTL

- Parametrised, set-associative, write-back, write-allocate L2 for the shared bus.
- Merges lookup and controller into one block, with configurable sets, ways and widths.
- Adds miss handling with dirty-victim writeback, per-set round-robin replacement and saturating statistics counters.
- Bus side: line-granular requests, one outstanding. Memory side: line-granular request/response channel.

---
 rtl/l2_assoc_cache.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/l2_assoc_cache.sv
// Set-associative write-back / write-allocate L2 with a single outstanding bus request,
// dirty-victim writeback, per-set round-robin replacement and saturating statistics.
module l2_assoc_cache #(
  parameter int LINE_ADDR_W = 26,
  parameter int LINE_BITS   = 512,
  parameter int SETS        = 64,
  parameter int WAYS        = 4,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   l2_req_valid,
  output logic                   l2_req_ready,
  input  logic [LINE_ADDR_W-1:0] l2_req_addr,
  input  logic                   l2_req_rw,
  input  logic [LINE_BITS-1:0]   l2_req_data,
  output logic                   l2_resp_valid,
  output logic [LINE_BITS-1:0]   l2_resp_data,
  output logic                   mem_req_valid,
  output logic                   mem_req_rw,
  output logic [LINE_ADDR_W-1:0] mem_req_addr,
  output logic [LINE_BITS-1:0]   mem_req_data,
  input  logic                   mem_req_ready,
  input  logic                   mem_resp_valid,
  input  logic [LINE_BITS-1:0]   mem_resp_data,
  output logic [CNT_W-1:0]       hit_count,
  output logic [CNT_W-1:0]       miss_count,
  output logic [CNT_W-1:0]       wb_count
);
  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = LINE_ADDR_W - IDX_W;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOOKUP    = 3'd1;
  localparam logic [2:0] WB_REQ    = 3'd2;
  localparam logic [2:0] FILL_REQ  = 3'd3;
  localparam logic [2:0] FILL_WAIT = 3'd4;
  localparam logic [2:0] RESP      = 3'd5;

  logic [2:0]             state_reg;
  logic [LINE_ADDR_W-1:0] addr_reg;
  logic                   rw_reg;
  logic [LINE_BITS-1:0]   wdata_reg;
  logic [LINE_BITS-1:0]   resp_data_reg;
  logic [WAY_W-1:0]       victim_reg;
  logic [CNT_W-1:0]       hit_reg, miss_reg, wb_reg;

  logic [WAYS-1:0]        valid_reg [SETS];
  logic [WAYS-1:0]        dirty_reg [SETS];
  logic [WAY_W-1:0]       ptr_reg   [SETS];
  logic [TAG_W-1:0]       tag_mem   [SETS][WAYS];
  logic [LINE_BITS-1:0]   data_mem  [SETS][WAYS];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [WAYS-1:0]        hit_vec;
  logic                   hit;
  logic [WAY_W-1:0]       hit_way, inv_way, victim_sel;
  logic                   has_inv, victim_dirty;
  logic                   inst_en;
  logic [WAY_W-1:0]       inst_way;
  logic [LINE_BITS-1:0]   inst_data;

  assign idx = addr_reg[IDX_W-1:0];
  assign tag = addr_reg[LINE_ADDR_W-1:IDX_W];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_hit
      assign hit_vec[gi] = valid_reg[idx][gi] && (tag_mem[idx][gi] == tag);
    end
  endgenerate

  assign hit = |hit_vec;

  // Descending scans leave the lowest matching way selected.
  always_comb begin
    hit_way = '0;
    inv_way = '0;
    has_inv = 1'b0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_reg[idx][w]) begin
        inv_way = WAY_W'(w);
        has_inv = 1'b1;
      end
    end
  end

  assign victim_sel   = has_inv ? inv_way : ptr_reg[idx];
  assign victim_dirty = valid_reg[idx][victim_sel] && dirty_reg[idx][victim_sel];

  always_comb begin
    inst_en   = 1'b0;
    inst_way  = victim_reg;
    inst_data = wdata_reg;
    case (state_reg)
      LOOKUP: begin
        if (hit) begin
          if (rw_reg) begin
            inst_en  = 1'b1;
            inst_way = hit_way;
          end
        end else if (!victim_dirty && rw_reg) begin
          inst_en  = 1'b1;
          inst_way = victim_sel;
        end
      end
      WB_REQ:    inst_en = mem_req_ready && rw_reg;
      FILL_WAIT: begin
        inst_en   = mem_resp_valid;
        inst_data = mem_resp_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (inst_en) begin
      data_mem[idx][inst_way] <= inst_data;
      tag_mem[idx][inst_way]  <= tag;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      rw_reg        <= 1'b0;
      wdata_reg     <= '0;
      resp_data_reg <= '0;
      victim_reg    <= '0;
      hit_reg       <= '0;
      miss_reg      <= '0;
      wb_reg        <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_reg[s] <= '0;
        dirty_reg[s] <= '0;
        ptr_reg[s]   <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: if (l2_req_valid) begin
          addr_reg  <= l2_req_addr;
          rw_reg    <= l2_req_rw;
          wdata_reg <= l2_req_data;
          state_reg <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (hit_reg != '1) hit_reg <= hit_reg + 1'b1;
            resp_data_reg <= rw_reg ? wdata_reg : data_mem[idx][hit_way];
            state_reg     <= RESP;
          end else begin
            if (miss_reg != '1) miss_reg <= miss_reg + 1'b1;
            victim_reg <= victim_sel;
            if (!has_inv && WAYS > 1) ptr_reg[idx] <= ptr_reg[idx] + 1'b1;
            if (victim_dirty) state_reg <= WB_REQ;
            else if (rw_reg) begin
              resp_data_reg <= wdata_reg;
              state_reg     <= RESP;
            end else state_reg <= FILL_REQ;
          end
        end
        WB_REQ: if (mem_req_ready) begin
          if (wb_reg != '1) wb_reg <= wb_reg + 1'b1;
          valid_reg[idx][victim_reg] <= 1'b0;
          dirty_reg[idx][victim_reg] <= 1'b0;
          if (rw_reg) begin
            resp_data_reg <= wdata_reg;
            state_reg     <= RESP;
          end else state_reg <= FILL_REQ;
        end
        FILL_REQ:  if (mem_req_ready) state_reg <= FILL_WAIT;
        FILL_WAIT: if (mem_resp_valid) begin
          resp_data_reg <= mem_resp_data;
          state_reg     <= RESP;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
      // Placed after the case so an install overrides the victim clear in WB_REQ.
      if (inst_en) begin
        valid_reg[idx][inst_way] <= 1'b1;
        dirty_reg[idx][inst_way] <= rw_reg;
      end
    end
  end

  assign l2_req_ready  = (state_reg == IDLE);
  assign l2_resp_valid = (state_reg == RESP);
  assign l2_resp_data  = resp_data_reg;
  assign mem_req_valid = (state_reg == WB_REQ) || (state_reg == FILL_REQ);
  assign mem_req_rw    = (state_reg == WB_REQ);
  assign mem_req_addr  = (state_reg == WB_REQ)   ? {tag_mem[idx][victim_reg], idx} :
                         (state_reg == FILL_REQ) ? addr_reg : '0;
  assign mem_req_data  = (state_reg == WB_REQ) ? data_mem[idx][victim_reg] : '0;
  assign hit_count     = hit_reg;
  assign miss_count    = miss_reg;
  assign wb_count      = wb_reg;
endmodule
